// File: rtl/dtree_pkg.sv
// Shared state type, default width and index-width helper for the leaf-tree ID loader.
package dtree_pkg;

  localparam int DEFAULT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtree_ack_wdog.sv
// Loadable down-counter shared by the ack timeout and the settle/check windows.
module dtree_ack_wdog #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)              count <= '0;
    else if (load)        count <= load_val;
    else if (clear)       count <= '0;
    else if (count != '0) count <= count - 1'b1;
  end

  // Loading N-1 makes expire true during the Nth cycle after the load edge.
  assign expire = (count == '0);

endmodule

// File: rtl/dtree_id_loader.sv
// Loads a unique ID into each leaf over valid/ack, then verifies every leaf echoes it back.
module dtree_id_loader
  import dtree_pkg::*;
#(
  parameter int NLEAF        = 4,
  parameter int W            = DEFAULT_W,
  parameter int SETTLE       = 10,
  parameter int CHECK_CYCLES = 3,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W-1:0]                id_base,
  output logic [NLEAF*W-1:0]          leaf_n,
  output logic [NLEAF-1:0]            leaf_vld,
  input  logic [NLEAF-1:0]            leaf_ack,
  input  logic [NLEAF*W-1:0]          leaf_echo,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [idx_width(NLEAF)-1:0] fail_idx
);

  localparam int IW   = idx_width(NLEAF);
  localparam int TMAX = (ACK_TIMEOUT > SETTLE) ? ACK_TIMEOUT : SETTLE;
  localparam int CMAX = (TMAX > CHECK_CYCLES) ? TMAX : CHECK_CYCLES;
  localparam int CW   = idx_width(CMAX);

  state_t               state, state_nx;
  logic [IW-1:0]        idx, idx_nx, idx_dn, first_bad;
  logic [W-1:0]         base, base_nx;
  logic [NLEAF*W-1:0]   leaf_n_nx;
  logic [NLEAF-1:0]     vld_nx, mism_vec;
  logic [IW-1:0]        fail_nx;
  logic                 pass_nx, mism, mism_nx;
  logic                 wd_load, wd_clear, wd_expire;
  logic [CW-1:0]        wd_val;

  dtree_ack_wdog #(.CW(CW)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .clear    (wd_clear),
    .load_val (wd_val),
    .expire   (wd_expire)
  );

  // Per-leaf compare; X/Z on an echo counts as a mismatch. Lowest failing index wins.
  always_comb begin
    mism_vec  = '0;
    first_bad = '0;
    for (int j = 0; j < NLEAF; j++)
      mism_vec[j] = (leaf_echo[j*W +: W] !== leaf_n[j*W +: W]);
    for (int j = NLEAF - 1; j >= 0; j--)
      if (mism_vec[j]) first_bad = IW'(j);
  end

  assign idx_dn   = idx - 1'b1;
  assign wd_clear = (state == ST_IDLE) || (state == ST_DONE);

  // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    base_nx   = base;
    leaf_n_nx = leaf_n;
    vld_nx    = leaf_vld;
    pass_nx   = pass;
    fail_nx   = fail_idx;
    mism_nx   = mism;
    wd_load   = 1'b0;
    wd_val    = '0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_nx   = id_base;
          idx_nx    = IW'(NLEAF - 1);
          leaf_n_nx = '0;
          leaf_n_nx[(NLEAF-1)*W +: W] = id_base + W'(NLEAF - 1);
          vld_nx    = '0;
          vld_nx[NLEAF-1] = 1'b1;
          pass_nx   = 1'b0;
          fail_nx   = '0;
          mism_nx   = 1'b0;
          wd_load   = 1'b1;
          wd_val    = CW'(ACK_TIMEOUT - 1);
          state_nx  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // An ack on the same edge as expiry still counts as accepted.
        if (leaf_ack[idx]) begin
          vld_nx  = '0;
          wd_load = 1'b1;
          if (idx == '0) begin
            wd_val   = CW'(SETTLE - 1);
            state_nx = ST_SETTLE;
          end else begin
            idx_nx         = idx_dn;
            vld_nx[idx_dn] = 1'b1;
            leaf_n_nx[int'(idx_dn)*W +: W] = base + W'(idx_dn);
            wd_val         = CW'(ACK_TIMEOUT - 1);
          end
        end else if (wd_expire) begin
          vld_nx   = '0;
          fail_nx  = idx;
          pass_nx  = 1'b0;
          state_nx = ST_DONE;
        end
      end

      ST_SETTLE: begin
        if (wd_expire) begin
          wd_load  = 1'b1;
          wd_val   = CW'(CHECK_CYCLES - 1);
          state_nx = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!mism && (|mism_vec)) begin
          mism_nx = 1'b1;
          fail_nx = first_bad;
        end
        if (wd_expire) begin
          pass_nx  = !(mism || (|mism_vec));
          state_nx = ST_DONE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      base     <= '0;
      leaf_n   <= '0;
      leaf_vld <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= '0;
      mism     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      base     <= base_nx;
      leaf_n   <= leaf_n_nx;
      leaf_vld <= vld_nx;
      busy     <= (state_nx == ST_LOAD) || (state_nx == ST_SETTLE) || (state_nx == ST_CHECK);
      done     <= (state_nx == ST_DONE);
      pass     <= pass_nx;
      fail_idx <= fail_nx;
      mism     <= mism_nx;
    end
  end

endmodule

// File: tb/tb_dtree_id_loader.sv
// Randomized scoreboard bench: a run-level model predicts vld timeline and final result per start.
module tb_dtree_id_loader;

  localparam int NLEAF        = 4;
  localparam int W            = 32;
  localparam int SETTLE       = 10;
  localparam int CHECK_CYCLES = 3;
  localparam int ACK_TIMEOUT  = 16;
  localparam int IW           = 2;
  localparam int NEVER        = 1000;

  logic               clk = 1'b0;
  logic               rst, start, busy, done, pass;
  logic [W-1:0]       id_base;
  logic [NLEAF*W-1:0] leaf_n, leaf_echo;
  logic [NLEAF-1:0]   leaf_vld, leaf_ack;
  logic [IW-1:0]      fail_idx;

  dtree_id_loader #(
    .NLEAF(NLEAF), .W(W), .SETTLE(SETTLE),
    .CHECK_CYCLES(CHECK_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .id_base(id_base),
    .leaf_n(leaf_n), .leaf_vld(leaf_vld), .leaf_ack(leaf_ack), .leaf_echo(leaf_echo),
    .busy(busy), .done(done), .pass(pass), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    int               cyc;
    logic [NLEAF-1:0] val;
  } vev_t;

  typedef struct packed {
    int                 done_cyc;
    logic               pass;
    logic [IW-1:0]      fail;
    logic [NLEAF*W-1:0] slices;
  } res_t;

  vev_t vq[$];
  res_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Run plan shared with the leaf responder.
  int                 dly [NLEAF];
  int                 cnt [NLEAF];
  logic [NLEAF-1:0]   bad_mask [CHECK_CYCLES];
  logic               use_x;
  int                 chk_edge0 = -1000;
  logic [NLEAF*W-1:0] exp_slices = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #3;
    end
  endtask

  task automatic clear_plan();
    for (int c = 0; c < CHECK_CYCLES; c++) bad_mask[c] = '0;
    use_x = 1'b0;
  endtask

  task automatic set_dly(input int v);
    for (int j = 0; j < NLEAF; j++) dly[j] = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"},  64'(leaf_vld), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_fail_idx"}, 64'(fail_idx), 64'd0);
    for (int j = 0; j < NLEAF; j++) check({tag, "_leaf_n"}, 64'(leaf_n[j*W +: W]), 64'd0);
  endtask

  // Leaf model: ack after dly[j] cycles of vld, random noise when not selected; echo = expected ID.
  int         slot;
  logic [W-1:0] echo_v;
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < NLEAF; j++) begin
      cnt[j]      = leaf_vld[j] ? cnt[j] + 1 : 0;
      leaf_ack[j] = leaf_vld[j] ? (cnt[j] > dly[j]) : 1'($urandom_range(0, 1));
    end
    for (int j = 0; j < NLEAF; j++) begin
      slot   = cyc + 1 - chk_edge0;
      echo_v = exp_slices[j*W +: W];
      if (slot >= 0 && slot < CHECK_CYCLES && bad_mask[slot][j])
        echo_v = use_x ? 'x : W'(7);
      leaf_echo[j*W +: W] = echo_v;
    end
  end

  // Monitor: pops expectations whenever the DUT presents vld or a rising done.
  vev_t ve;
  res_t re;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (leaf_vld != '0) begin
      if (vq.size() == 0) check("vld_unexpected", 64'(leaf_vld), 64'd0);
      else begin
        ve = vq.pop_front();
        check("vld_cycle", 64'(cyc), 64'(ve.cyc));
        check("vld_onehot", 64'(leaf_vld), 64'(ve.val));
        check("busy_in_load", 64'(busy), 64'd1);
      end
    end
    if (done && !done_q) begin
      if (rq.size() == 0) check("done_unexpected", 64'(done), 64'd0);
      else begin
        re = rq.pop_front();
        check("done_cycle", 64'(cyc), 64'(re.done_cyc));
        check("pass", 64'(pass), 64'(re.pass));
        check("fail_idx", 64'(fail_idx), 64'(re.fail));
        check("busy_at_done", 64'(busy), 64'd0);
        for (int j = 0; j < NLEAF; j++)
          check("leaf_n", 64'(leaf_n[j*W +: W]), 64'(re.slices[j*W +: W]));
      end
    end
    done_q = done;
  end

  // Issues one start and predicts the whole run from the handshake/window rules.
  task automatic run_case(input logic [W-1:0] base, input int abort_at, input bit spurious);
    res_t             exp;
    vev_t             ev;
    int               a, rise, ack_e, t;
    logic [NLEAF-1:0] bad;
    bit               timed_out;
    a             = cyc + 1;
    rise          = a;
    timed_out     = 1'b0;
    exp.done_cyc  = 0;
    exp.pass      = 1'b1;
    exp.fail      = '0;
    exp.slices    = '0;
    for (int i = NLEAF - 1; i >= 0; i--) begin
      exp.slices[i*W +: W] = base + W'(i);
      ev.val = NLEAF'(1) << i;
      if (dly[i] < ACK_TIMEOUT) begin
        ack_e = rise + 1 + dly[i];
        for (int c = rise; c < ack_e; c++) begin ev.cyc = c; vq.push_back(ev); end
        rise = ack_e;
      end else begin
        for (int c = rise; c < rise + ACK_TIMEOUT; c++) begin ev.cyc = c; vq.push_back(ev); end
        exp.done_cyc = rise + ACK_TIMEOUT;
        exp.pass     = 1'b0;
        exp.fail     = IW'(i);
        timed_out    = 1'b1;
        break;
      end
    end
    chk_edge0 = -1000;
    if (!timed_out) begin
      chk_edge0    = rise + SETTLE + 1;
      exp.done_cyc = rise + SETTLE + CHECK_CYCLES;
      for (int c = 0; c < CHECK_CYCLES; c++) begin
        for (int j = 0; j < NLEAF; j++)
          bad[j] = bad_mask[c][j] && (use_x || exp.slices[j*W +: W] != W'(7));
        if (exp.pass && bad != '0) begin
          exp.pass = 1'b0;
          for (int j = NLEAF - 1; j >= 0; j--) if (bad[j]) exp.fail = IW'(j);
        end
      end
    end
    exp_slices = exp.slices;
    rq.push_back(exp);

    start = 1'b1; id_base = base;
    @(posedge clk); #3;
    start = 1'b0; id_base = $urandom;

    if (abort_at > 0) begin
      wait_until(a + abort_at - 1);
      rst = 1'b1;
      @(posedge clk); #3;
      rst = 1'b0;
      vq.delete();
      rq.delete();
      chk_edge0 = -1000;
      check_idle("abort");
    end else begin
      if (spurious) begin
        t = int'($urandom_range(a + 1, exp.done_cyc - 1));
        wait_until(t - 1);
        start = 1'b1; id_base = $urandom;
        @(posedge clk); #3;
        start = 1'b0;
      end
      wait_until(exp.done_cyc + 1);
      check("vld_drained", 64'(vq.size()), 64'd0);
      check("done_seen", 64'(rq.size()), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; id_base = '0; leaf_ack = '0; leaf_echo = '0;
    set_dly(0);
    for (int j = 0; j < NLEAF; j++) cnt[j] = 0;
    clear_plan();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    check_idle("reset");

    clear_plan(); set_dly(1);     run_case(32'd0, 0, 1'b0);            // nominal
    clear_plan(); set_dly(0);     run_case(32'h0000_0040, 0, 1'b0);    // immediate acks
    clear_plan();
    for (int j = 0; j < NLEAF; j++) dly[j] = int'($urandom_range(0, 3));
    run_case(32'hFFFF_FFFE, 0, 1'b0);                                  // wrap
    clear_plan(); set_dly(1); dly[2] = NEVER;
    run_case(32'h0000_1000, 0, 1'b0);                                  // timeout on leaf 2
    clear_plan(); set_dly(0);
    bad_mask[1] = 4'b0010; bad_mask[2] = 4'b1000;
    run_case(32'h0000_0050, 0, 1'b0);                                  // echo mismatch
    clear_plan(); set_dly(0);
    bad_mask[0] = 4'b0001; use_x = 1'b1;
    run_case(32'h1234_5678, 0, 1'b0);                                  // X echo on leaf 0
    clear_plan(); set_dly(3);     run_case(32'h0000_0200, 3, 1'b0);    // reset mid-LOAD
    clear_plan(); set_dly(0);     run_case(32'h0000_0300, 16, 1'b0);   // reset mid-CHECK
    clear_plan(); set_dly(1);     run_case(32'd100, 0, 1'b1);          // rerun, start while busy
    run_case(32'd100, 0, 1'b0);                                        // restart from DONE

    for (int r = 0; r < 24; r++) begin
      clear_plan();
      for (int j = 0; j < NLEAF; j++)
        dly[j] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        use_x = 1'($urandom_range(0, 1));
        for (int c = 0; c < CHECK_CYCLES; c++)
          bad_mask[c] = NLEAF'($urandom_range(0, 15)) & NLEAF'($urandom_range(0, 15));
      end
      run_case($urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0,
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #3; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dtree_id_loader.md
Name: dtree_id_loader

Overview:
- Upstream stage for the per-instance leaf tree (bmod→cmod→dmod style chains).
- Assigns each leaf a unique ID over a per-leaf valid/ack handshake, in descending index order.
- Waits a settle window, then checks every leaf's echoed local value against its assigned ID for a fixed window.
- Reports done/pass and the first failing leaf; gives the tree a single, reset-controlled source of `n` values instead of tie-offs.

Parameters:
- NLEAF, 4, number of leaf instances (≥1).
- W, 32, ID / echo width.
- SETTLE, 10, idle cycles between the last ack and the start of checking (≥1).
- CHECK_CYCLES, 3, consecutive cycles compared in CHECK (≥1).
- ACK_TIMEOUT, 16, maximum cycles `leaf_vld[i]` waits for its ack (≥1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load/check run.
- id_base  in  W  base ID, sampled on an accepted start.
- leaf_n  out  NLEAF*W  ID driven to each leaf; slice i = bits [i*W +: W].
- leaf_vld  out  NLEAF  per-leaf load valid (one-hot or zero).
- leaf_ack  in  NLEAF  per-leaf load acknowledge.
- leaf_echo  in  NLEAF*W  per-leaf registered copy of its `n` (clocal/dlocal).
- busy  out  1  high in LOAD, SETTLE and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1; 1 = all leaves acked and matched.
- fail_idx  out  max(1,$clog2(NLEAF))  failing leaf index; 0 when pass.

Behaviour:
- Reset (any state, mid-run included): state=IDLE; leaf_n=0, leaf_vld=0, busy=0, done=0, pass=0, fail_idx=0; all counters cleared. Nothing from the aborted run persists.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE/DONE + start=1: latch id_base, set i=NLEAF-1, go to LOAD next cycle; done and pass clear on that edge. start is ignored in LOAD/SETTLE/CHECK.
- LOAD:
  - leaf_vld[i]=1, one-hot, and leaf_n slice i = id_base+i modulo 2^W (wraps, no saturation). The slice is updated on the same edge that raises vld[i].
  - leaf_ack[j] is sampled only while leaf_vld[j]=1; acks on other bits are ignored.
  - Ack seen at edge k: vld[i] drops at edge k and vld[i-1] rises at edge k. Back-to-back acks load one leaf per cycle. An ack already high when vld rises counts on the first edge.
  - Ack after leaf 0: vld→0, go to SETTLE.
  - Timeout: timer restarts on each vld rise. If ACK_TIMEOUT cycles pass with no ack, record fail_idx=i, pass=0, go to DONE (skip SETTLE/CHECK).
  - Loaded leaf_n slices hold their value until the next accepted start or reset. Unloaded slices stay 0.
- SETTLE: exactly SETTLE cycles, then CHECK.
- CHECK:
  - Exactly CHECK_CYCLES cycles; each cycle compares leaf_echo[j] with leaf_n[j] for all j, using !== semantics (X/Z counts as mismatch).
  - First mismatching cycle records the lowest mismatching index into fail_idx (sticky); later cycles cannot overwrite it.
  - Then go to DONE; pass=1 only if no mismatch occurred.
- DONE: done=1, busy=0; holds until start or rst.
- NLEAF=1: LOAD is a single handshake; fail_idx is 1 bit, always 0.
- Latency with immediate acks: start→done = 1 + NLEAF + SETTLE + CHECK_CYCLES edges.

Decomposition:
- Package dtree_pkg:
  - state enum (IDLE, LOAD, SETTLE, CHECK, DONE);
  - localparam function for idx width (max(1,clog2));
  - default W.
- One sub-module, dtree_ack_wdog: a down-counter with load/clear/expire, reused for the ACK_TIMEOUT and SETTLE/CHECK counts; width from the larger parameter.

Test Plan:
- Nominal: id_base=0, acks returned 1 cycle after vld, echoes mirror leaf_n → vld order 3,2,1,0; leaf_n={3,2,1,0}; done after 1+4×2+10+3 edges; pass=1, fail_idx=0.
- Immediate acks (leaf_ack=4'hF): one leaf per cycle; done exactly 18 edges after start; pass=1.
- Wrap: id_base=32'hFFFF_FFFE → leaf_n slices {1,0,FFFF_FFFF,FFFF_FFFE} for leaves 3..0; pass=1.
- Timeout: leaf 2 never acks → vld[2] high 16 cycles, then done=1, pass=0, fail_idx=2; leaves 1 and 0 never see vld; slices 1,0 stay 0.
- Echo mismatch: leaf 1 echo forced to 7 in CHECK cycle 2, and leaf 3 in cycle 3 → pass=0, fail_idx=1. Separately, X on leaf 0 echo → fail_idx=0.
- Reset mid-LOAD and mid-CHECK → next cycle all outputs 0, IDLE. A start during busy is ignored. A fresh start after DONE reruns cleanly with the new id_base=100 → leaf_n={103,102,101,100}.
